// File: rtl/memory_port_arbiter.sv
// Two-requester arbiter for the read/write port B of a memory_block.
// Grants on phase-0 cycles, accesses on phase-1 cycles, returns read data.
module memory_port_arbiter #(
    parameter int data_width     = 16,
    parameter int address_width  = 10,
    parameter int fixed_priority = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic                     req0_write,
    input  logic [address_width-1:0] req0_address,
    input  logic [data_width-1:0]    req0_data,
    output logic                     req0_ready,
    output logic                     resp0_valid,
    output logic [data_width-1:0]    resp0_data,
    input  logic                     req1_valid,
    input  logic                     req1_write,
    input  logic [address_width-1:0] req1_address,
    input  logic [data_width-1:0]    req1_data,
    output logic                     req1_ready,
    output logic                     resp1_valid,
    output logic [data_width-1:0]    resp1_data,
    output logic                     mem_write_clock,
    output logic                     mem_write_enable,
    output logic [address_width-1:0] mem_portB_address,
    output logic [data_width-1:0]    mem_data_in,
    input  logic [data_width-1:0]    mem_portB_out
);

    logic phase;
    logic last_grant;
    logic req0_wins;
    logic grant0;
    logic grant1;
    logic rd1_valid;
    logic rd1_id;
    logic rd2_valid;
    logic rd2_id;

    // last_grant = 1 means requester 1 was served last, so 0 wins a tie
    always_comb begin
        req0_wins = (fixed_priority != 0) || last_grant;
        grant0 = !reset && !phase && req0_valid
               && (req0_wins || !req1_valid);
        grant1 = !reset && !phase && req1_valid
               && !(req0_valid && req0_wins);
    end

    assign req0_ready      = grant0;
    assign req1_ready      = grant1;
    assign mem_write_clock = phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase             <= 1'b0;
            last_grant        <= 1'b1;
            mem_write_enable  <= 1'b0;
            mem_portB_address <= '0;
            mem_data_in       <= '0;
            rd1_valid         <= 1'b0;
            rd1_id            <= 1'b0;
            rd2_valid         <= 1'b0;
            rd2_id            <= 1'b0;
            resp0_valid       <= 1'b0;
            resp1_valid       <= 1'b0;
            resp0_data        <= '0;
            resp1_data        <= '0;
        end else begin
            phase <= !phase;
            mem_write_enable <= (grant0 && req0_write)
                              || (grant1 && req1_write);
            if (grant0) begin
                mem_portB_address <= req0_address;
                mem_data_in       <= req0_data;
                last_grant        <= 1'b0;
            end else if (grant1) begin
                mem_portB_address <= req1_address;
                mem_data_in       <= req1_data;
                last_grant        <= 1'b1;
            end
            rd1_valid <= (grant0 && !req0_write)
                       || (grant1 && !req1_write);
            rd1_id    <= grant1;
            rd2_valid <= rd1_valid;
            rd2_id    <= rd1_id;
            // portB_out carries the read word during the rd2 cycle
            resp0_valid <= rd2_valid && !rd2_id;
            resp1_valid <= rd2_valid && rd2_id;
            if (rd2_valid && !rd2_id)
                resp0_data <= mem_portB_out;
            if (rd2_valid && rd2_id)
                resp1_data <= mem_portB_out;
        end
    end

endmodule
